// File: rtl/alu_muldiv_pkg.sv
// Shared types for the multi-cycle multiply/divide unit.
//   muldiv_op_e : operation select sampled with start
//   flags_t     : execution-stage condition flag word (same layout the ALU uses)
//   md_state_e  : sequencer state encoding
package alu_muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULU = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIVU = 2'd2,
        MD_DIV  = 2'd3
    } muldiv_op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic cy;
    } flags_t;

    typedef logic [1:0] md_state_e;

    localparam md_state_e MD_S_IDLE = 2'd0;
    localparam md_state_e MD_S_PREP = 2'd1;
    localparam md_state_e MD_S_ITER = 2'd2;
    localparam md_state_e MD_S_FIX  = 2'd3;

    function automatic logic f_is_div(input muldiv_op_e op);
        return (op == MD_DIVU) || (op == MD_DIV);
    endfunction

    function automatic logic f_is_signed(input muldiv_op_e op);
        return (op == MD_MUL) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// Request/response bundle between the execution sequencer (master) and the
// multiply/divide unit (slave).
//   start/op/wide/ta/th/tb/flags_in : request, sampled when start && !busy
//   busy/done/div_error/result/flags: status and response
interface alu_muldiv_if
    import alu_muldiv_pkg::*;
#(
    parameter int DATA_W = 16
) ();

    logic                  start;
    muldiv_op_e            op;
    logic                  wide;
    logic [DATA_W-1:0]     ta;
    logic [DATA_W-1:0]     th;
    logic [DATA_W-1:0]     tb;
    flags_t                flags_in;
    logic                  busy;
    logic                  done;
    logic                  div_error;
    logic [2*DATA_W-1:0]   result;
    flags_t                flags;

    modport master (
        output start, op, wide, ta, th, tb, flags_in,
        input  busy, done, div_error, result, flags
    );

    modport slave (
        input  start, op, wide, ta, th, tb, flags_in,
        output busy, done, div_error, result, flags
    );

endinterface

// File: rtl/alu_muldiv.sv
// Multi-cycle multiply/divide unit (MULU, MUL, DIVU, DIV) on byte (n = DATA_W/2)
// or word (n = DATA_W) operands. Shift-add multiply and restoring divide run on
// magnitudes in one shared 2*DATA_W+1 bit accumulator; signs are applied in FIX.
//
// Ports:
//   i_clk  : clock
//   i_rst  : asynchronous active-high reset
//   io_md  : alu_muldiv_if.slave request/response bundle
//
// Parameters:
//   DATA_W   : word width (even, >= 8)
//   FAST_MUL : 1 = multiply computed combinationally in FIX, skipping PREP/ITER
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; operands latched on accept
// PREP  | magnitudes formed, divide errors checked, accumulator loaded
// ITER  | one product / quotient bit per cycle, counter n-1 down to 0
// FIX   | sign fix-up, signed range check, result/flags written with done
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int FAST_MUL = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    alu_muldiv_if.slave io_md
);

    localparam int W  = DATA_W;
    localparam int H  = DATA_W / 2;
    localparam int AW = 2 * DATA_W + 1;
    localparam int CW = $clog2(DATA_W);

    localparam logic [CW-1:0] CNT_WIDE    = CW'(W - 1);
    localparam logic [CW-1:0] CNT_NARROW  = CW'(H - 1);
    localparam logic [W-1:0]  QMAX_WIDE   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  QMAX_NARROW = {{(W-H+1){1'b0}}, {(H-1){1'b1}}};

    function automatic logic [2*W-1:0] f_neg_dw(input logic [2*W-1:0] v);
        return (~v) + (2*W)'(1);
    endfunction

    function automatic logic [W-1:0] f_neg_w(input logic [W-1:0] v);
        return (~v) + W'(1);
    endfunction

    function automatic logic [2*W-1:0] f_mag_dw(input logic [2*W-1:0] v, input logic neg);
        return neg ? f_neg_dw(v) : v;
    endfunction

    function automatic logic [W-1:0] f_mag_w(input logic [W-1:0] v, input logic neg);
        return neg ? f_neg_w(v) : v;
    endfunction

    md_state_e          r_state;
    muldiv_op_e         r_op;
    logic               r_wide;
    logic [W-1:0]       r_ta;
    logic [W-1:0]       r_th;
    logic [W-1:0]       r_tb;
    flags_t             r_flags_in;
    logic [AW-1:0]      r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_done;
    logic               r_div_error;
    logic [2*W-1:0]     r_result;
    flags_t             r_flags;

    logic               w_sgn_op;
    logic               w_div;
    logic [2*W-1:0]     w_a_sx;
    logic [W-1:0]       w_b_sx;
    logic               w_sgn_a;
    logic               w_sgn_b;
    logic [2*W-1:0]     w_mag_a;
    logic [W-1:0]       w_mag_b;

    logic               w_b_zero;
    logic [W-1:0]       w_hi_a;
    logic               w_prep_err;
    logic [AW-1:0]      w_sh_base;
    logic [AW-1:0]      w_sh;
    logic [AW-1:0]      w_mul_sum;
    logic [AW-1:0]      w_shl;
    logic [AW:0]        w_div_diff;
    logic [AW-1:0]      w_acc_next;

    logic [2*W-1:0]     w_fast_prod;
    logic [2*W-1:0]     w_prod_mag;
    logic [2*W-1:0]     w_prod;
    logic               w_mflag;
    logic [W-1:0]       w_qmag;
    logic [W-1:0]       w_rmag;
    logic               w_q_neg;
    logic [W-1:0]       w_qmax;
    logic               w_q_err;
    logic [W-1:0]       w_quot;
    logic [W-1:0]       w_rem;
    logic [2*W-1:0]     w_fix_result;
    flags_t             w_fix_flags;

    // Operand decode from the latched request. The dividend is 2n bits: the
    // whole of ta for narrow divides, {th, ta} for wide ones.
    always_comb begin
        w_sgn_op = f_is_signed(r_op);
        w_div    = f_is_div(r_op);
        if (w_div) begin
            w_a_sx = r_wide ? {r_th, r_ta} : {{W{w_sgn_op & r_ta[W-1]}}, r_ta};
        end else begin
            w_a_sx = r_wide ? {{W{w_sgn_op & r_ta[W-1]}}, r_ta}
                            : {{(2*W-H){w_sgn_op & r_ta[H-1]}}, r_ta[H-1:0]};
        end
        w_b_sx  = r_wide ? r_tb : {{(W-H){w_sgn_op & r_tb[H-1]}}, r_tb[H-1:0]};
        w_sgn_a = w_sgn_op & w_a_sx[2*W-1];
        w_sgn_b = w_sgn_op & w_b_sx[W-1];
        w_mag_a = f_mag_dw(w_a_sx, w_sgn_a);
        w_mag_b = f_mag_w(w_b_sx, w_sgn_b);
    end

    // Iteration datapath. The second operand is aligned to bit n so narrow and
    // wide share one adder/subtractor: multiply adds the multiplicand there and
    // shifts right; divide shifts left and trial-subtracts the divisor there.
    always_comb begin
        w_b_zero   = r_wide ? (r_tb == '0) : (r_tb[H-1:0] == '0);
        w_hi_a     = r_wide ? w_mag_a[2*W-1:W] : {{(W-H){1'b0}}, w_mag_a[W-1:H]};
        w_prep_err = w_div & (w_b_zero | (w_hi_a >= w_mag_b));
        w_sh_base  = {{(W+1){1'b0}}, (w_div ? w_mag_b : w_mag_a[W-1:0])};
        w_sh       = r_wide ? (w_sh_base << W) : (w_sh_base << H);
        w_mul_sum  = r_acc + (r_acc[0] ? w_sh : '0);
        w_shl      = {r_acc[AW-2:0], 1'b0};
        w_div_diff = {1'b0, w_shl} - {1'b0, w_sh};
        if (w_div) begin
            w_acc_next = w_div_diff[AW] ? w_shl : (w_div_diff[AW-1:0] | AW'(1));
        end else begin
            w_acc_next = w_mul_sum >> 1;
        end
    end

    // Sign fix-up, signed quotient range check and result packing.
    always_comb begin
        w_fast_prod = {{W{1'b0}}, w_mag_a[W-1:0]} * {{W{1'b0}}, w_mag_b};
        w_prod_mag  = (FAST_MUL != 0) ? w_fast_prod : r_acc[2*W-1:0];
        w_prod      = f_mag_dw(w_prod_mag, w_sgn_a ^ w_sgn_b);
        if (r_wide) begin
            w_mflag = w_sgn_op ? (w_prod[2*W-1:W] != {W{w_prod[W-1]}})
                               : (w_prod[2*W-1:W] != '0);
        end else begin
            w_mflag = w_sgn_op ? (w_prod[W-1:H] != {H{w_prod[H-1]}})
                               : (w_prod[W-1:H] != '0);
        end

        w_qmag  = r_wide ? r_acc[W-1:0]     : {{(W-H){1'b0}}, r_acc[H-1:0]};
        w_rmag  = r_wide ? r_acc[2*W-1:W]   : {{(W-H){1'b0}}, r_acc[W-1:H]};
        w_q_neg = w_sgn_a ^ w_sgn_b;
        w_qmax  = r_wide ? QMAX_WIDE : QMAX_NARROW;
        // A negative quotient may reach one further: -2^(n-1).
        if (w_q_neg) begin
            w_qmax = w_qmax + W'(1);
        end
        w_q_err = w_sgn_op & (w_qmag > w_qmax);
        w_quot  = f_mag_w(w_qmag, w_q_neg);
        w_rem   = f_mag_w(w_rmag, w_sgn_a);

        w_fix_flags = r_flags_in;
        if (w_div) begin
            w_fix_result = r_wide ? {w_rem, w_quot}
                                  : {{W{1'b0}}, w_rem[H-1:0], w_quot[H-1:0]};
        end else begin
            w_fix_result   = r_wide ? w_prod : {{W{1'b0}}, w_prod[W-1:0]};
            w_fix_flags.cy = w_mflag;
            w_fix_flags.v  = w_mflag;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= MD_S_IDLE;
            r_op        <= MD_MULU;
            r_wide      <= 1'b0;
            r_ta        <= '0;
            r_th        <= '0;
            r_tb        <= '0;
            r_flags_in  <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_div_error <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
        end else begin
            r_done      <= 1'b0;
            r_div_error <= 1'b0;
            case (r_state)
                MD_S_IDLE: begin
                    if (io_md.start) begin
                        r_op       <= io_md.op;
                        r_wide     <= io_md.wide;
                        r_ta       <= io_md.ta;
                        r_th       <= io_md.th;
                        r_tb       <= io_md.tb;
                        r_flags_in <= io_md.flags_in;
                        if ((FAST_MUL != 0) && !f_is_div(io_md.op)) begin
                            r_state <= MD_S_FIX;
                        end else begin
                            r_state <= MD_S_PREP;
                        end
                    end
                end
                MD_S_PREP: begin
                    if (w_prep_err) begin
                        r_done      <= 1'b1;
                        r_div_error <= 1'b1;
                        r_state     <= MD_S_IDLE;
                    end else begin
                        r_acc   <= w_div ? {1'b0, w_mag_a} : {{(W+1){1'b0}}, w_mag_b};
                        r_cnt   <= r_wide ? CNT_WIDE : CNT_NARROW;
                        r_state <= MD_S_ITER;
                    end
                end
                MD_S_ITER: begin
                    r_acc <= w_acc_next;
                    if (r_cnt == '0) begin
                        r_state <= MD_S_FIX;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                MD_S_FIX: begin
                    r_done <= 1'b1;
                    if (w_div && w_q_err) begin
                        r_div_error <= 1'b1;
                    end else begin
                        r_result <= w_fix_result;
                        r_flags  <= w_fix_flags;
                    end
                    r_state <= MD_S_IDLE;
                end
                default: r_state <= MD_S_IDLE;
            endcase
        end
    end

    assign io_md.busy      = (r_state != MD_S_IDLE);
    assign io_md.done      = r_done;
    assign io_md.div_error = r_div_error;
    assign io_md.result    = r_result;
    assign io_md.flags     = r_flags;

endmodule
